// File: rtl/alu_sequencer.sv
// ALU command sequencer: register-file read, ALU execute, write-back.
// Holds the processor status flags {C,F,L,N,Z} between commands.
module alu_sequencer #(
    parameter logic [7:0] NOP_OP = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_op,
    input  logic [3:0]  cmd_rd,
    input  logic [3:0]  cmd_rs,
    input  logic [15:0] cmd_imm,
    input  logic        cmd_use_imm,
    input  logic        cmd_wb,
    input  logic        abort,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    input  logic [15:0] rf_rdata_a,
    input  logic [15:0] rf_rdata_b,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_op,
    output logic        alu_cin,
    input  logic [15:0] alu_c,
    input  logic        alu_carry,
    input  logic        alu_flag,
    input  logic        alu_low,
    input  logic        alu_neg,
    input  logic        alu_zero,
    input  logic        psr_we,
    input  logic [4:0]  psr_wdata,
    output logic [4:0]  psr,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        accept;
    logic [7:0]  op_q;
    logic [3:0]  rd_q;
    logic [3:0]  rs_q;
    logic [15:0] imm_q;
    logic        use_imm_q;
    logic        wb_q;
    logic [15:0] res_c;
    logic [4:0]  res_f;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == WB);
    assign accept    = cmd_valid & cmd_ready;

    // Read addresses come straight from the latched fields, so they
    // keep the last command's indices until the next accept.
    assign rf_raddr_a = rd_q;
    assign rf_raddr_b = rs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = READ;
            READ: state_nxt = abort ? IDLE : EXEC;
            EXEC: state_nxt = abort ? IDLE : WB;
            WB:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_op   = NOP_OP;
        alu_cin  = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (state == EXEC) begin
            alu_a   = rf_rdata_a;
            alu_b   = use_imm_q ? imm_q : rf_rdata_b;
            alu_op  = op_q;
            alu_cin = psr[4];
        end
        if (state == WB) begin
            rf_we    = wb_q;
            rf_waddr = rd_q;
            rf_wdata = res_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            wb_q      <= 1'b0;
        end else if (accept) begin
            op_q      <= cmd_op;
            rd_q      <= cmd_rd;
            rs_q      <= cmd_rs;
            imm_q     <= cmd_imm;
            use_imm_q <= cmd_use_imm;
            wb_q      <= cmd_wb;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_c <= '0;
            res_f <= '0;
        end else if (state == EXEC && !abort) begin
            res_c <= alu_c;
            res_f <= {alu_carry, alu_flag, alu_low, alu_neg, alu_zero};
        end
    end

    // Software load only while idle; it lands before the accepted
    // command reaches EXEC, so that command sees the new carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psr <= '0;
        end else if (state == IDLE && psr_we) begin
            psr <= psr_wdata;
        end else if (state == WB && op_q != NOP_OP) begin
            psr <= res_f;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, reset corner cases,
// then random commands against a transaction-level reference model.
module tb_alu_sequencer;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_ADDCU = 8'h02;
    localparam logic [7:0] OP_CMP   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_AND   = 8'h05;

    localparam logic [15:0] INIT [16] = '{
        16'h0000, 16'h0005, 16'h0003, 16'hFFFF,
        16'h0002, 16'h0007, 16'hAAAA, 16'h1234,
        16'hFFFF, 16'h0001, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000
    };

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [3:0]  cmd_rd;
    logic [3:0]  cmd_rs;
    logic [15:0] cmd_imm;
    logic        cmd_use_imm;
    logic        cmd_wb;
    logic        abort;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_op;
    logic        alu_cin;
    logic [15:0] alu_c;
    logic        alu_carry;
    logic        alu_flag;
    logic        alu_low;
    logic        alu_neg;
    logic        alu_zero;
    logic        psr_we;
    logic [4:0]  psr_wdata;
    logic [4:0]  psr;
    logic        busy;
    logic        done;

    logic        preload;
    logic [15:0] rf  [16];
    logic [15:0] mrf [16];
    logic [4:0]  mpsr;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] imm;
        logic        use_imm;
        logic        wb;
        int          abort_at;
        logic        pre_en;
        logic [4:0]  pre_val;
        logic        hostile;
        logic        exp_we;
        logic [15:0] exp_wdata;
        logic [4:0]  exp_psr;
    } vec_t;

    alu_sequencer #(.NOP_OP(OP_NOP)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs),
        .cmd_imm(cmd_imm), .cmd_use_imm(cmd_use_imm), .cmd_wb(cmd_wb),
        .abort(abort),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_c(alu_c), .alu_carry(alu_carry), .alu_flag(alu_flag),
        .alu_low(alu_low), .alu_neg(alu_neg), .alu_zero(alu_zero),
        .psr_we(psr_we), .psr_wdata(psr_wdata), .psr(psr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Returns {carry, overflow, low, neg, zero, result}.
    function automatic logic [20:0] alu_f(input logic [7:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic cin);
        logic [16:0] s;
        logic [15:0] c;
        logic        cy;
        logic        ov;
        s  = '0;
        ov = 1'b0;
        case (op)
            OP_ADD: begin
                s  = {1'b0, a} + {1'b0, b};
                ov = (a[15] == b[15]) && (s[15] != a[15]);
            end
            OP_ADDCU: begin
                s  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
                ov = (a[15] == b[15]) && (s[15] != a[15]);
            end
            OP_CMP, OP_SUB: begin
                s  = {1'b0, a} - {1'b0, b};
                s[16] = ~s[16];
                ov = (a[15] != b[15]) && (s[15] != a[15]);
            end
            OP_AND: s = {1'b0, a & b};
            default: return '0;
        endcase
        c  = s[15:0];
        cy = s[16];
        return {cy, ov, a < b, c[15], c == 16'd0, c};
    endfunction

    always_comb begin
        {alu_carry, alu_flag, alu_low, alu_neg, alu_zero, alu_c} =
            alu_f(alu_op, alu_a, alu_b, alu_cin);
    end

    always @(posedge clk) begin
        rf_rdata_a <= rf[rf_raddr_a];
        rf_rdata_b <= rf[rf_raddr_b];
        if (preload) begin
            for (int i = 0; i < 16; i++) rf[i] <= INIT[i];
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
        input logic [15:0] imm, input logic use_imm, input logic wb,
        input int abort_at, input logic pre_en, input logic [4:0] pre_val,
        input logic hostile, input logic exp_we,
        input logic [15:0] exp_wdata, input logic [4:0] exp_psr);
        vec_t v;
        v.op = op; v.rd = rd; v.rs = rs; v.imm = imm;
        v.use_imm = use_imm; v.wb = wb; v.abort_at = abort_at;
        v.pre_en = pre_en; v.pre_val = pre_val; v.hostile = hostile;
        v.exp_we = exp_we; v.exp_wdata = exp_wdata; v.exp_psr = exp_psr;
        return v;
    endfunction

    // Entered and left at a negedge with the DUT idle. abort_at:
    // 1=READ, 2=EXEC, 3=WB, 4=accept cycle, 0=none.
    task automatic run(input vec_t v);
        logic [4:0]  base;
        logic [15:0] ea;
        logic [15:0] eb;
        base = v.pre_en ? v.pre_val : mpsr;
        ea   = mrf[v.rd];
        eb   = v.use_imm ? v.imm : mrf[v.rs];
        chk("ready_idle", 32'(cmd_ready), 32'(1));
        cmd_valid   = 1'b1;
        cmd_op      = v.op;
        cmd_rd      = v.rd;
        cmd_rs      = v.rs;
        cmd_imm     = v.imm;
        cmd_use_imm = v.use_imm;
        cmd_wb      = v.wb;
        psr_we      = v.pre_en;
        psr_wdata   = v.pre_val;
        abort       = (v.abort_at == 4);
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_op      = 8'($urandom);
        cmd_rd      = 4'($urandom);
        cmd_rs      = 4'($urandom);
        cmd_imm     = 16'($urandom);
        cmd_use_imm = 1'($urandom);
        cmd_wb      = 1'($urandom);
        psr_we      = v.hostile;
        psr_wdata   = 5'($urandom);
        abort       = (v.abort_at == 1);
        chk("busy_read", 32'(busy), 32'(1));
        chk("raddr_a", 32'(rf_raddr_a), 32'(v.rd));
        chk("raddr_b", 32'(rf_raddr_b), 32'(v.rs));
        chk("we_read", 32'(rf_we), 32'(0));
        @(negedge clk);
        if (v.abort_at == 1) begin
            abort  = 1'b0;
            psr_we = 1'b0;
            chk("ready_abrt_rd", 32'(cmd_ready), 32'(1));
            chk("psr_abrt_rd", 32'(psr), 32'(base));
        end else begin
            chk("alu_a", 32'(alu_a), 32'(ea));
            chk("alu_b", 32'(alu_b), 32'(eb));
            chk("alu_op", 32'(alu_op), 32'(v.op));
            chk("alu_cin", 32'(alu_cin), 32'(base[4]));
            chk("done_exec", 32'(done), 32'(0));
            abort = (v.abort_at == 2);
            @(negedge clk);
            psr_we = 1'b0;
            if (v.abort_at == 2) begin
                abort = 1'b0;
                chk("ready_abrt_ex", 32'(cmd_ready), 32'(1));
                chk("done_abrt_ex", 32'(done), 32'(0));
                chk("we_abrt_ex", 32'(rf_we), 32'(0));
                chk("psr_abrt_ex", 32'(psr), 32'(base));
            end else begin
                chk("done_wb", 32'(done), 32'(1));
                chk("we_wb", 32'(rf_we), 32'(v.exp_we));
                if (v.exp_we) begin
                    chk("waddr", 32'(rf_waddr), 32'(v.rd));
                    chk("wdata", 32'(rf_wdata), 32'(v.exp_wdata));
                end
                chk("aluop_wb", 32'(alu_op), 32'(OP_NOP));
                chk("psr_wb", 32'(psr), 32'(base));
                abort = (v.abort_at == 3);
                @(negedge clk);
                abort = 1'b0;
                chk("done_after", 32'(done), 32'(0));
                chk("ready_after", 32'(cmd_ready), 32'(1));
                chk("psr_after", 32'(psr), 32'(v.exp_psr));
            end
        end
        mpsr = v.exp_psr;
        if (v.exp_we) mrf[v.rd] = v.exp_wdata;
    endtask

    vec_t tbl [11];

    initial begin
        tbl[0]  = mk(OP_ADD,   1, 2, 16'h0000, 0, 1, 0, 0, 5'b00000, 0,
                     1, 16'h0008, 5'b00000);
        tbl[1]  = mk(OP_ADDCU, 3, 0, 16'h0000, 1, 1, 0, 1, 5'b10000, 0,
                     1, 16'h0000, 5'b10001);
        tbl[2]  = mk(OP_CMP,   4, 5, 16'h0000, 0, 0, 0, 0, 5'b00000, 0,
                     0, 16'h0000, 5'b00110);
        tbl[3]  = mk(OP_ADD,   1, 2, 16'h0000, 0, 1, 2, 0, 5'b00000, 0,
                     0, 16'h0000, 5'b00110);
        tbl[4]  = mk(OP_NOP,   6, 0, 16'h0000, 0, 1, 0, 0, 5'b00000, 0,
                     1, 16'h0000, 5'b00110);
        tbl[5]  = mk(OP_ADD,   1, 2, 16'h0000, 0, 1, 4, 0, 5'b00000, 0,
                     1, 16'h000B, 5'b00000);
        tbl[6]  = mk(OP_ADD,   2, 2, 16'h0000, 0, 1, 3, 0, 5'b00000, 1,
                     1, 16'h0006, 5'b00000);
        tbl[7]  = mk(OP_ADDCU, 1, 2, 16'h0000, 0, 1, 1, 0, 5'b00000, 0,
                     0, 16'h0000, 5'b00000);
        tbl[8]  = mk(OP_ADD,   7, 0, 16'h0010, 1, 1, 0, 0, 5'b00000, 0,
                     1, 16'h1244, 5'b00000);
        tbl[9]  = mk(OP_ADD,   8, 9, 16'h0000, 0, 1, 0, 0, 5'b00000, 0,
                     1, 16'h0000, 5'b10001);
        tbl[10] = mk(OP_ADDCU, 10, 11, 16'h0000, 0, 1, 0, 0, 5'b00000, 0,
                     1, 16'h0001, 5'b00000);

        reset = 1'b1;
        preload = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_imm = '0;
        cmd_use_imm = 1'b0; cmd_wb = 1'b0;
        abort = 1'b0; psr_we = 1'b0; psr_wdata = '0;
        for (int i = 0; i < 16; i++) mrf[i] = INIT[i];
        mpsr = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_we", 32'(rf_we), 32'(0));
        chk("rst_psr", 32'(psr), 32'(0));
        chk("rst_aluop", 32'(alu_op), 32'(OP_NOP));
        chk("rst_alu_ab", {alu_a, alu_b}, 32'(0));
        chk("rst_cin", 32'(alu_cin), 32'(0));
        chk("rst_raddr", 32'({rf_raddr_a, rf_raddr_b}), 32'(0));
        chk("rst_wport", 32'({rf_waddr, rf_wdata}), 32'(0));
        reset = 1'b0;
        preload = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run(tbl[i]);

        // Reset landing in WB must suppress the pending write.
        cmd_valid = 1'b1;
        cmd_op = OP_ADD; cmd_rd = 4'd1; cmd_rs = 4'd2;
        cmd_use_imm = 1'b0; cmd_wb = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("wb_pre_rst", 32'(rf_we), 32'(1));
        #2 reset = 1'b1;
        #1;
        chk("rst_wb_we", 32'(rf_we), 32'(0));
        chk("rst_wb_psr", 32'(psr), 32'(0));
        chk("rst_wb_ready", 32'(cmd_ready), 32'(1));
        chk("rst_wb_done", 32'(done), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        mpsr = '0;
        @(negedge clk);
        run(mk(OP_NOP, 0, 0, 16'h0000, 0, 0, 0, 0, 5'b00000, 1,
               0, 16'h0000, 5'b00000));

        for (int n = 0; n < 80; n++) begin
            vec_t v;
            logic [20:0] r;
            logic [4:0] base;
            case ($urandom_range(0, 5))
                0: v.op = OP_NOP;
                1: v.op = OP_ADD;
                2: v.op = OP_ADDCU;
                3: v.op = OP_CMP;
                4: v.op = OP_SUB;
                default: v.op = OP_AND;
            endcase
            v.rd = 4'($urandom);
            v.rs = 4'($urandom);
            v.imm = 16'($urandom);
            v.use_imm = 1'($urandom);
            v.wb = 1'($urandom);
            v.abort_at = ($urandom_range(0, 3) == 0) ?
                         int'($urandom_range(1, 4)) : 0;
            v.pre_en = ($urandom_range(0, 3) == 0);
            v.pre_val = 5'($urandom);
            v.hostile = 1'($urandom);
            base = v.pre_en ? v.pre_val : mpsr;
            r = alu_f(v.op, mrf[v.rd], v.use_imm ? v.imm : mrf[v.rs],
                      base[4]);
            if (v.abort_at == 1 || v.abort_at == 2) begin
                v.exp_we = 1'b0;
                v.exp_wdata = '0;
                v.exp_psr = base;
            end else begin
                v.exp_we = v.wb;
                v.exp_wdata = r[15:0];
                v.exp_psr = (v.op == OP_NOP) ? base : r[20:16];
            end
            run(v);
        end

        for (int i = 0; i < 16; i++) chk("rf_final", 32'(rf[i]), 32'(mrf[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: NOP_OP, 8'h00, ALU opcode value that leaves psr unchanged.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present; cmd_ready  output  1  sequencer can accept.
REQ-005 cmd_op  input  8  ALU opcode; cmd_rd, cmd_rs  input  4 each  destination/source register indices.
REQ-006 cmd_imm  input  16  immediate; cmd_use_imm  input  1  B operand = cmd_imm; cmd_wb  input  1  write result to cmd_rd.
REQ-007 abort  input  1  cancel in-flight command.
REQ-008 rf_raddr_a, rf_raddr_b  output  4 each; rf_rdata_a, rf_rdata_b  input  16 each  (register file, 1-cycle synchronous read).
REQ-009 rf_we  output  1; rf_waddr  output  4; rf_wdata  output  16  register file write port.
REQ-010 alu_a, alu_b  output  16; alu_op  output  8; alu_cin  output  1  to combinational ALU.
REQ-011 alu_c  input  16; alu_carry, alu_flag, alu_low, alu_neg, alu_zero  input  1 each  from ALU.
REQ-012 psr_we  input  1; psr_wdata  input  5  software load of psr, bit order {C,F,L,N,Z} = [4:0].
REQ-013 psr  output  5  flag register {C,F,L,N,Z}; busy  output  1; done  output  1.

Function
REQ-014 FSM states SHALL be IDLE, READ, EXEC, WB; IDLE->READ on cmd_valid&cmd_ready; READ->EXEC; EXEC->WB; WB->IDLE unconditionally.
REQ-015 cmd_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-016 On accept, all cmd_* fields SHALL be latched; later cmd_* changes SHALL not affect the in-flight command.
REQ-017 In READ, rf_raddr_a = latched rd, rf_raddr_b = latched rs; in all other states both SHALL hold their last value.
REQ-018 In EXEC, alu_a = rf_rdata_a, alu_b = use_imm ? imm : rf_rdata_b, alu_op = latched op, alu_cin = psr[4]; outside EXEC alu_a=alu_b=0, alu_op=NOP_OP, alu_cin=0.
REQ-019 At the EXEC->WB edge, alu_c and the five ALU flags SHALL be captured into result registers.
REQ-020 In WB, rf_we = latched wb, rf_waddr = latched rd, rf_wdata = captured result; rf_we SHALL be 0 in every other state.
REQ-021 At the WB->IDLE edge, psr SHALL load captured {carry,flag,low,neg,zero} unless latched op==NOP_OP.
REQ-022 done SHALL be high for exactly the WB cycle; latency accept-edge to done = 3 cycles; max throughput 1 command per 4 cycles.
REQ-023 psr_we SHALL load psr_wdata only when state==IDLE; ignored otherwise.
REQ-024 psr_we and accept in the same cycle: psr load SHALL occur, and the accepted command SHALL see the new psr[4] as alu_cin.
REQ-025 abort in READ or EXEC SHALL force IDLE at next edge: no rf write, no psr update, no done.
REQ-026 abort in WB or IDLE SHALL be ignored; the WB write and psr update complete.
REQ-027 Consecutive commands SHALL see psr from the previous command (carry chaining for multi-word add).

Reset
REQ-028 Reset SHALL force state=IDLE, psr=5'b0, result registers=0, latched fields=0, rf_we=0, done=0, busy=0, cmd_ready=1, alu_op=NOP_OP, all other outputs 0.
REQ-029 Reset asserted mid-command SHALL cancel it with no rf write or psr update, including during WB.

Verification
REQ-030 R1=16'h0005, R2=16'h0003, ADD rd=1 rs=2 wb=1 -> rf write R1=16'h0008 in WB, done 3 cycles after accept, psr Z=0.
REQ-031 psr_we with 5'b10000, then ADDCU imm=16'h0000 on R3=16'hFFFF, use_imm=1 -> alu_cin=1, R3=16'h0000, psr C=1, Z=1.
REQ-032 CMP R4=16'h0002 vs R5=16'h0007 wb=0 -> rf_we never high, psr L=1, N=1, Z=0.
REQ-033 Accept command, assert abort during EXEC -> IDLE next cycle, no rf_we, psr unchanged, no done; next command accepted normally.
REQ-034 Assert reset during WB -> rf_we low immediately, psr=0, cmd_ready=1; psr_we in READ ignored in a separate run.
REQ-035 NOP_OP command with wb=1 -> rf write of 16'h0000 (ALU output), psr unchanged from prior value.
